// File: rtl/fifo_pkg.sv
// Shared FIFO constants, depth derivation and parameter legality check.
// No logic, no latency; no flow control lives here.
package fifo_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 4;
  localparam int DEF_AE_TH = 2;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  localparam int DEF_AF_TH = depth_of(DEF_AW) - 2;

  // AE_TH < AF_TH keeps the two almost flags from both asserting at one occupancy
  function automatic bit thresholds_ok(input int dw, input int aw,
                                       input int af_th, input int ae_th);
    return (dw >= 1) && (aw >= 1) && (ae_th >= 0) &&
           (ae_th < af_th) && (af_th <= depth_of(aw));
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param; the FIFO takes the slave side.
// Request/response wires only; clock and reset stay separate ports.
interface fifo_sync_param_if import fifo_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);
  logic          clr;
  logic          WREQ;
  logic [DW-1:0] WD;
  logic          RREQ;
  logic [DW-1:0] RD;
  logic          f;
  logic          e;
  logic          af;
  logic          ae;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          udf;

  modport master (
    output clr, WREQ, WD, RREQ,
    input  RD, f, e, af, ae, cnt, ovf, udf
  );

  modport slave (
    input  clr, WREQ, WD, RREQ,
    output RD, f, e, af, ae, cnt, ovf, udf
  );
endinterface

// File: rtl/fifo_dpram.sv
// DEPTH x DW storage: synchronous write, registered (FWFT=0) or async (FWFT=1) read.
// Registered read has 1-cycle latency; no backpressure, callers gate i_we/i_re.
module fifo_dpram import fifo_pkg::*; #(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int FWFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  if (FWFT == 0) begin : g_reg_rd
    logic [DW-1:0] r_rd;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       r_rd <= '0;
      else if (i_clr) r_rd <= '0;
      else if (i_re)  r_rd <= r_mem[i_raddr];
    end

    assign o_rdata = r_rd;
  end else begin : g_fwft_rd
    // Head entry is always visible; reset/flush/pop only move the pointer upstream
    logic w_unused;
    assign w_unused = rst ^ i_clr ^ i_re;
    assign o_rdata  = r_mem[i_raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with thresholds, occupancy, sticky errors, flush and optional FWFT.
// Writes on full / reads on empty are dropped and flagged; FWFT=0 read data 1 cycle after request.
module fifo_sync_param import fifo_pkg::*; #(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int AF_TH = depth_of(AW) - 2,
  parameter int AE_TH = DEF_AE_TH,
  parameter int FWFT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  fifo_sync_param_if.slave   bus
);

  if (!thresholds_ok(DW, AW, AF_TH, AE_TH)) begin : g_bad_params
    $error("fifo_sync_param: illegal DW/AW/AF_TH/AE_TH combination");
  end

  localparam logic [AW:0] AF_V = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_V = (AW+1)'(AE_TH);

  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          r_ovf;
  logic          r_udf;
  logic          w_e;
  logic          w_f;
  logic [AW:0]   w_cnt;
  logic          w_wacc;
  logic          w_racc;
  logic [DW-1:0] w_rd;

  assign w_e   = (r_wp == r_rp);
  assign w_f   = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign w_cnt = r_wp - r_rp;

  // Acceptance uses only the pre-edge flags, so a same-cycle pop never frees room for a push
  assign w_wacc = bus.WREQ && !w_f && !bus.clr;
  assign w_racc = bus.RREQ && !w_e && !bus.clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (bus.clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wacc)              r_wp  <= r_wp + 1'b1;
      if (w_racc)              r_rp  <= r_rp + 1'b1;
      if (bus.WREQ && w_f)     r_ovf <= 1'b1;
      if (bus.RREQ && w_e)     r_udf <= 1'b1;
    end
  end

  fifo_dpram #(
    .DW   (DW),
    .AW   (AW),
    .FWFT (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.clr),
    .i_we    (w_wacc),
    .i_waddr (r_wp[AW-1:0]),
    .i_wdata (bus.WD),
    .i_re    (w_racc),
    .i_raddr (r_rp[AW-1:0]),
    .o_rdata (w_rd)
  );

  assign bus.RD  = w_rd;
  assign bus.e   = w_e;
  assign bus.f   = w_f;
  assign bus.cnt = w_cnt;
  assign bus.af  = (w_cnt >= AF_V);
  assign bus.ae  = (w_cnt <= AE_V);
  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO: the next generation of the team's 32-bit asynchronous-pointer FIFO, generalised in data width and depth. It adds almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between the APB slave front end and the downstream data consumer, and replaces the fixed-size FIFO wherever producer and consumer share `clk`.

## Interface
- `DW`, 32, data width in bits (≥1)
- `AW`, 4, address width; `DEPTH` = 2**AW entries (AW ≥ 1)
- `AF_TH`, DEPTH-2, almost-full threshold; legal range AE_TH < AF_TH ≤ DEPTH
- `AE_TH`, 2, almost-empty threshold; legal range 0 ≤ AE_TH < AF_TH
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous flush
- `WREQ`  in  1  write request
- `WD`  in  DW  write data
- `RREQ`  in  1  read request (FWFT=0) or pop (FWFT=1)
- `RD`  out  DW  read data
- `f`, `e`  out  1  full, empty
- `af`, `ae`  out  1  almost full, almost empty
- `cnt`  out  AW+1  occupancy, range 0..DEPTH
- `ovf`, `udf`  out  1  sticky overflow, sticky underflow

## Operation
- Pointers `wp` and `rp` are AW+1 bits wide; the low AW bits address memory and the MSB is the wrap bit.
- Flags and count are combinational from the registered pointers:
  - `e` = (wp == rp)
  - `f` = (low bits equal) and (MSBs differ)
  - `cnt` = wp − rp, modulo 2**(AW+1)
  - `af` = (cnt ≥ AF_TH); `ae` = (cnt ≤ AE_TH)
- Write accept: WREQ && !f. On accept, mem[wp] ← WD and wp increments.
  - Write on full is rejected even if a read is accepted in the same cycle.
- Read accept: RREQ && !e. On accept, rp increments.
  - Read on empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: cnt is unchanged; both pointers advance.
- Pointers wrap naturally: DEPTH−1 → 0 on the low bits, and the MSB toggles.
- FWFT=0:
  - On an accepted read, RD ← mem[rp] at the clock edge.
  - RD holds its value otherwise, including on rejected reads.
- FWFT=1:
  - RD = mem[rp] combinationally; RREQ pops the head entry.
  - RD is valid only while e=0; the bench ignores RD while e=1.
- Error flags:
  - `ovf` sets on WREQ && f; `udf` sets on RREQ && e.
  - Both stay set until `clr` or reset.
- `clr`:
  - wp, rp, ovf and udf go to 0; RD goes to 0 when FWFT=0.
  - clr overrides WREQ and RREQ in the same cycle: both are ignored and no flag sets.
  - Memory contents are not cleared.
- Memory contents are never reset.

## Timing
- Reset (`rst`=0), asynchronous and immediate:
  - wp=rp=0, RD=0 (FWFT=0), ovf=udf=0
  - hence e=1, f=0, ae=1, af=0, cnt=0
- Reset mid-operation discards all entries; the first edge after `rst` rises behaves as a fresh FIFO.
- Write at edge N:
  - cnt, e, f, af and ae reflect it immediately after edge N.
  - A read is acceptable at edge N+1.
- FWFT=0 read latency: accepted at edge N, data on RD after edge N (one cycle from request).
- FWFT=1: the head entry appears on RD after the write edge that made e=0; zero-cycle pop.
- ovf/udf assert after the edge at which the offending request is sampled.

## Structure
- Shared package `fifo_pkg`:
  - DEPTH derivation function
  - default DW/AW/threshold constants
  - parameter-legality check (elaboration-time error on illegal thresholds)
- One sub-module, `fifo_dpram`: DEPTH×DW array with a synchronous write port and two read forms (registered read for FWFT=0, asynchronous read for FWFT=1). Pointer, flag and error logic live in `fifo_sync_param`.

## Test plan
Parameters DW=32, AW=2 (DEPTH=4), AF_TH=3, AE_TH=1 unless stated.
- Reset then idle → e=1, ae=1, f=0, af=0, cnt=0, RD=0, ovf=udf=0.
- Write 0x11, 0x22, 0x33, 0x44, then 0x55 → after the 3rd write af=1; after the 4th f=1, cnt=4; 0x55 is rejected and ovf=1; cnt stays 4.
- FWFT=0, from full, read 5 times → RD = 0x11, 0x22, 0x33, 0x44 one cycle after each request; the 5th read sets udf=1 with RD holding 0x44; e=1.
- Concurrent WREQ+RREQ for 10 cycles with cnt=2, data 0x100..0x109 → cnt stays 2; pointers wrap; read data is in order with no loss.
- FWFT=1: write 0xAB → RD=0xAB right after the write edge; RREQ pops → e=1.
- clr asserted together with WREQ while cnt=3 and ovf=1 → next cycle cnt=0, e=1, ovf=0, write ignored. Mid-stream `rst` low → all outputs return to reset values asynchronously.
